// File: rtl/toggle_activity_monitor.sv
// Counts bit toggles on D over a WIN_LEN-cycle window started by START; result held on RES_VALID/RES_READY.
// Latency: RES_VALID rises WIN_LEN edges after the START edge. Backpressure: result held in HOLD until RES_READY.
// Optional per-cycle peak toggle tracking (PEAK port) when TOGGLE_MON_PEAK_TRACK_EN is defined.
module toggle_activity_monitor #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 16,
   parameter int WIN_LEN = 64
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       START,
   input  logic [WIDTH-1:0]           D,
   output logic                       BUSY,
   output logic                       RES_VALID,
   input  logic                       RES_READY,
   output logic [CNT_W-1:0]           TOGGLES,
   output logic [CNT_W-1:0]           CYCLES,
   output logic                       OVF
`ifdef TOGGLE_MON_PEAK_TRACK_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] PEAK
`endif
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("toggle_activity_monitor: WIDTH must be in 1..64");
   end
   if (WIN_LEN < 1 || (CNT_W < 31 && WIN_LEN > (1 << CNT_W) - 1)) begin : g_bad_win_len
      $error("toggle_activity_monitor: WIN_LEN must be in 1..2^CNT_W-1");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] prev;
   logic [PC_W-1:0]  pc;
   logic [SUM_W-1:0] sum;
   logic             over;
   logic             last_cyc;

   always_comb begin
      pc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pc = pc + PC_W'(D[i] ^ prev[i]);
      end
   end

   // Sum is one bit wider than either operand so saturation is detected without wrap.
   assign sum      = SUM_W'(TOGGLES) + SUM_W'(pc);
   assign over     = (sum > SUM_W'({CNT_W{1'b1}}));
   assign last_cyc = (CYCLES == CNT_W'(WIN_LEN - 1));

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state     <= ST_IDLE;
         BUSY      <= 1'b0;
         RES_VALID <= 1'b0;
         TOGGLES   <= '0;
         CYCLES    <= '0;
         OVF       <= 1'b0;
         prev      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  prev    <= D;
                  TOGGLES <= '0;
                  CYCLES  <= '0;
                  OVF     <= 1'b0;
                  state   <= ST_RUN;
                  BUSY    <= 1'b1;
               end
            end
            ST_RUN: begin
               prev    <= D;
               TOGGLES <= over ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
               OVF     <= OVF | over;
               CYCLES  <= CYCLES + CNT_W'(1);
               if (last_cyc) begin
                  state     <= ST_HOLD;
                  RES_VALID <= 1'b1;
               end
            end
            ST_HOLD: begin
               // START in the accepting cycle is deliberately dropped.
               if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  state     <= ST_IDLE;
                  BUSY      <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               BUSY      <= 1'b0;
               RES_VALID <= 1'b0;
            end
         endcase
      end
   end

`ifdef TOGGLE_MON_PEAK_TRACK_EN
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         PEAK <= '0;
      end else if (state == ST_IDLE && START) begin
         PEAK <= '0;
      end else if (state == ST_RUN && pc > PEAK) begin
         PEAK <= pc;
      end
   end
`endif

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: windowed reference model on the main instance plus directed literal checks.
`timescale 1ns/100ps
module tb_toggle_activity_monitor;

   logic CLK;
   logic RSTN;

   // main instance: WIDTH=8, CNT_W=16, WIN_LEN=4
   logic        start, rdy, busy, valid, ovf;
   logic [7:0]  d;
   logic [15:0] tog, cyc;
   // single-bit instance: WIDTH=1, WIN_LEN=8
   logic        start1, rdy1, busy1, valid1, ovf1;
   logic [0:0]  d1;
   logic [15:0] tog1, cyc1;
   // saturating instance: CNT_W=4, WIN_LEN=4
   logic        start2, rdy2, busy2, valid2, ovf2;
   logic [7:0]  d2;
   logic [3:0]  tog2, cyc2;
`ifdef TOGGLE_MON_PEAK_TRACK_EN
   logic [3:0]  peak, peak2;
   logic [0:0]  peak1;
`endif

   int checks = 0;
   int errors = 0;

   toggle_activity_monitor #(.WIDTH(8), .CNT_W(16), .WIN_LEN(4)) u_main (
      .CLK(CLK), .RSTN(RSTN), .START(start), .D(d), .BUSY(busy), .RES_VALID(valid),
      .RES_READY(rdy), .TOGGLES(tog), .CYCLES(cyc), .OVF(ovf)
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      , .PEAK(peak)
`endif
   );

   toggle_activity_monitor #(.WIDTH(1), .CNT_W(16), .WIN_LEN(8)) u_w1 (
      .CLK(CLK), .RSTN(RSTN), .START(start1), .D(d1), .BUSY(busy1), .RES_VALID(valid1),
      .RES_READY(rdy1), .TOGGLES(tog1), .CYCLES(cyc1), .OVF(ovf1)
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      , .PEAK(peak1)
`endif
   );

   toggle_activity_monitor #(.WIDTH(8), .CNT_W(4), .WIN_LEN(4)) u_sat (
      .CLK(CLK), .RSTN(RSTN), .START(start2), .D(d2), .BUSY(busy2), .RES_VALID(valid2),
      .RES_READY(rdy2), .TOGGLES(tog2), .CYCLES(cyc2), .OVF(ovf2)
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      , .PEAK(peak2)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model for u_main: collects the samples of a window and derives the result from them.
   localparam int MWIN = 4;
   localparam int MMAX = 65535;
   int         m_state = 0;
   logic       m_busy  = 1'b0;
   logic       m_valid = 1'b0;
   logic       m_ovf   = 1'b0;
   int         m_tog   = 0;
   int         m_cyc   = 0;
   int         m_peak  = 0;
   logic [7:0] m_s[$];

   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         m_state = 0; m_busy = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
         m_tog = 0; m_cyc = 0; m_peak = 0;
         m_s.delete();
      end else begin
         case (m_state)
            0: if (start) begin
                  m_s.delete();
                  m_s.push_back(d);
                  m_tog = 0; m_cyc = 0; m_ovf = 1'b0; m_peak = 0;
                  m_state = 1; m_busy = 1'b1;
               end
            1: begin
                  m_s.push_back(d);
                  if (m_s.size() - 1 == MWIN) begin
                     int total;
                     int pk;
                     total = 0; pk = 0;
                     for (int i = 1; i < m_s.size(); i++) begin
                        int pc;
                        pc = $countones(m_s[i] ^ m_s[i-1]);
                        total += pc;
                        if (pc > pk) pk = pc;
                     end
                     m_tog   = (total > MMAX) ? MMAX : total;
                     m_ovf   = (total > MMAX);
                     m_cyc   = m_s.size() - 1;
                     m_peak  = pk;
                     m_state = 2; m_valid = 1'b1;
                  end
               end
            default: if (rdy) begin
                  m_state = 0; m_valid = 1'b0; m_busy = 1'b0;
               end
         endcase
      end
   end

   always @(negedge CLK) begin
      chk("busy", busy, m_busy);
      chk("res_valid", valid, m_valid);
      if (m_state != 1) begin
         chk("toggles", tog, m_tog);
         chk("cycles", cyc, m_cyc);
         chk("ovf", ovf, m_ovf);
`ifdef TOGGLE_MON_PEAK_TRACK_EN
         chk("peak", peak, m_peak);
`endif
      end
   end

   initial begin
      RSTN = 1'b1;
      start = 0; rdy = 0; d = 0;
      start1 = 0; rdy1 = 0; d1 = 0;
      start2 = 0; rdy2 = 0; d2 = 0;
      #1 RSTN = 1'b0;
      #6;
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_toggles", tog, 0);
      chk("rst_cycles", cyc, 0);
      @(negedge CLK) RSTN = 1'b1;

      // alternating 00/FF: every bit toggles on each of the 4 edges
      @(negedge CLK); start = 1; d = 8'h00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK); start = 0; d = (k % 2) ? 8'hFF : 8'h00;
      end
      chk("alt_valid_early", valid, 0);
      @(negedge CLK);
      chk("alt_valid", valid, 1);
      chk("alt_toggles", tog, 32);
      chk("alt_cycles", cyc, 4);
      chk("alt_ovf", ovf, 0);
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      chk("alt_peak", peak, 8);
`endif
      rdy = 1;
      @(negedge CLK); rdy = 1;
      chk("alt_accept_busy", busy, 0);
      chk("alt_retained", tog, 32);
      @(negedge CLK); rdy = 0;

      // constant bus
      start = 1; d = 8'h5A;
      @(negedge CLK); start = 0;
      repeat (4) @(negedge CLK);
      chk("const_valid", valid, 1);
      chk("const_toggles", tog, 0);
      chk("const_cycles", cyc, 4);
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      chk("const_peak", peak, 0);
`endif
      rdy = 1;
      @(negedge CLK); rdy = 0;

      // hold under backpressure: 01,03,06,09,0C -> 1+2+4+2 = 9 toggles
      start = 1; d = 8'h01;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK); start = 0; d = 8'(k * 3);
      end
      @(negedge CLK);
      for (int k = 0; k < 10; k++) begin
         start = k[0]; d = 8'(k * 37 + 5); rdy = 0;
         @(negedge CLK);
         chk("hold_busy", busy, 1);
         chk("hold_toggles", tog, 9);
      end
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      chk("hold_peak", peak, 4);
`endif
      rdy = 1; start = 1;
      @(negedge CLK);
      chk("accept_start_busy", busy, 0);
      chk("accept_start_valid", valid, 0);
      rdy = 0; start = 1;
      @(negedge CLK);
      chk("restart_busy", busy, 1);
      start = 0; d = 8'h33;
      repeat (4) @(negedge CLK);
      chk("restart_valid", valid, 1);
      chk("restart_cycles", cyc, 4);
      rdy = 1;
      @(negedge CLK); rdy = 0;

      // asynchronous reset mid-window at CYCLES=2
      start = 1; d = 8'h00;
      @(negedge CLK); start = 0; d = 8'h0F;
      @(negedge CLK); d = 8'hF0;
      @(negedge CLK);
      chk("mid_cycles", cyc, 2);
      #2 RSTN = 1'b0;
      #0.5;
      chk("arst_busy", busy, 0);
      chk("arst_valid", valid, 0);
      chk("arst_toggles", tog, 0);
      chk("arst_cycles", cyc, 0);
      #0.5 RSTN = 1'b1;
      @(negedge CLK); start = 1; d = 8'h81;
      @(negedge CLK); start = 0;
      repeat (4) @(negedge CLK);
      chk("post_rst_valid", valid, 1);
      chk("post_rst_cycles", cyc, 4);
      rdy = 1;
      @(negedge CLK); rdy = 0;

      // WIDTH=1, D toggles every other cycle over 8 edges -> 4 toggles
      start1 = 1; d1 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge CLK); start1 = 0; d1 = 1'((k >> 1) & 1);
      end
      chk("w1_valid_early", valid1, 0);
      @(negedge CLK);
      chk("w1_valid", valid1, 1);
      chk("w1_toggles", tog1, 4);
      chk("w1_cycles", cyc1, 8);
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      chk("w1_peak", peak1, 1);
`endif
      rdy1 = 1;
      @(negedge CLK); rdy1 = 0;
      chk("w1_idle", busy1, 0);

      // CNT_W=4 saturates at 15 with 32 raw toggles
      start2 = 1; d2 = 8'h00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK); start2 = 0; d2 = (k % 2) ? 8'hFF : 8'h00;
      end
      @(negedge CLK);
      chk("sat_valid", valid2, 1);
      chk("sat_toggles", tog2, 15);
      chk("sat_ovf", ovf2, 1);
      chk("sat_cycles", cyc2, 4);
`ifdef TOGGLE_MON_PEAK_TRACK_EN
      chk("sat_peak", peak2, 8);
`endif
      rdy2 = 1;
      @(negedge CLK); rdy2 = 0;
      @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
